seg7_shift_ctrl: RTL and testbench

//  Sequencer for the serial 7-segment display chain. On request, captures a

---
 rtl/seg7_shift_ctrl.sv | 132 +++++++++++++
 tb/tb_seg7_shift_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_shift_ctrl.sv
// Serial 7-segment chain sequencer: captures a segment frame, shifts it out MSB-first
// on a divided serial clock, then pulses the latch enable. One request can queue behind a busy frame.
module seg7_shift_ctrl #(
    parameter int WIDTH = 64,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pdata,
    output logic             busy,
    output logic             done,
    output logic             seg_clk,
    output logic             seg_sout,
    output logic             SEG_PEN,
    output logic             seg_clrn
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_END  = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic [DW-1:0]    dcnt_q;
    logic             pend_q;
    logic             restart_q;
    logic             busy_q;
    logic             done_q;
    logic             sclk_q;
    logic             sout_q;
    logic             pen_q;
    logic             clrn_q;
    logic             phase_end;

    assign phase_end = (dcnt_q == DIV_END);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            pend_q    <= 1'b0;
            restart_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sout_q    <= 1'b0;
            pen_q     <= 1'b1;
            clrn_q    <= 1'b0;
        end else begin
            clrn_q <= 1'b1;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // restart_q marks the one-cycle gap after a frame whose successor
                    // was already captured on the completion edge.
                    if (restart_q || start) begin
                        if (!restart_q) begin
                            shreg_q <= pdata;
                            sout_q  <= pdata[WIDTH-1];
                        end else begin
                            sout_q  <= shreg_q[WIDTH-1];
                        end
                        restart_q <= 1'b0;
                        state_q   <= SHIFT;
                        cnt_q     <= '0;
                        dcnt_q    <= '0;
                        busy_q    <= 1'b1;
                        pen_q     <= 1'b0;
                        sclk_q    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        pend_q <= 1'b1;
                    end
                    if (phase_end) begin
                        dcnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            cnt_q  <= cnt_q + 1'b1;
                            if (cnt_q == LAST_BIT) begin
                                state_q <= LATCH;
                                sout_q  <= 1'b0;
                            end else begin
                                shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                                sout_q  <= shreg_q[WIDTH-2];
                            end
                        end
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        dcnt_q  <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        pen_q   <= 1'b1;
                        done_q  <= 1'b1;
                        pend_q  <= 1'b0;
                        if (pend_q || start) begin
                            shreg_q   <= pdata;
                            restart_q <= 1'b1;
                        end
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                        if (start) begin
                            pend_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign seg_clk  = sclk_q;
    assign seg_sout = sout_q;
    assign SEG_PEN  = pen_q;
    assign seg_clrn = clrn_q;

endmodule

// File: tb/tb_seg7_shift_ctrl.sv
// Directed bench for seg7_shift_ctrl: a WIDTH=8/DIV=1 instance for bit-order checks
// and a default-parameter instance for latency, back-to-back, queueing and abort cases.
module tb_seg7_shift_ctrl;

    logic clk;
    logic rst;

    logic        s_start, s_busy, s_done, s_clk, s_sout, s_pen, s_clrn;
    logic [7:0]  s_pdata;
    logic        d_start, d_busy, d_done, d_clk, d_sout, d_pen, d_clrn;
    logic [63:0] d_pdata;

    int total = 0;
    int bad   = 0;

    seg7_shift_ctrl #(.WIDTH(8), .DIV(1)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .pdata(s_pdata),
        .busy(s_busy), .done(s_done), .seg_clk(s_clk), .seg_sout(s_sout),
        .SEG_PEN(s_pen), .seg_clrn(s_clrn)
    );

    seg7_shift_ctrl u_dflt (
        .clk(clk), .rst(rst), .start(d_start), .pdata(d_pdata),
        .busy(d_busy), .done(d_done), .seg_clk(d_clk), .seg_sout(d_sout),
        .SEG_PEN(d_pen), .seg_clrn(d_clrn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame monitor for the default instance, sampled on the falling edge.
    int          cyc = 0;
    bit          mon_clr = 1'b1;
    logic [63:0] fbits;
    int          rises, penlo, penhi, busy_pen_err;
    bit          seen_lo;
    logic        prevclk;
    int          done_cyc[$];
    logic [63:0] fr_bits[$];
    int          fr_rises[$];
    int          lo_runs[$];
    int          hi_runs[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_clr) begin
                fbits = '0; rises = 0; penlo = 0; penhi = 0; busy_pen_err = 0;
                seen_lo = 1'b0; prevclk = d_clk;
                done_cyc.delete(); fr_bits.delete(); fr_rises.delete();
                lo_runs.delete(); hi_runs.delete();
            end else begin
                if (d_busy && d_pen) busy_pen_err++;
                if (!d_pen) begin
                    if (seen_lo && penhi > 0) hi_runs.push_back(penhi);
                    penhi = 0; penlo++; seen_lo = 1'b1;
                end else begin
                    if (penlo > 0) lo_runs.push_back(penlo);
                    penlo = 0;
                    if (seen_lo) penhi++;
                end
                if (d_clk && !prevclk) begin
                    fbits = {fbits[62:0], d_sout};
                    rises++;
                end
                prevclk = d_clk;
                if (d_done) begin
                    done_cyc.push_back(cyc);
                    fr_bits.push_back(fbits);
                    fr_rises.push_back(rises);
                    fbits = '0; rises = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    int         n, t0, done_at, srises;
    logic [7:0] sbits;
    logic       sprev;
    logic       s_busy_at_done, s_pen_at_done;

    localparam logic [63:0] PAT_A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PAT_B = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] PAT_C = 64'hA5A5_0F0F_C3C3_9999;
    localparam logic [63:0] PAT_D = 64'h1111_2222_3333_4444;
    localparam logic [63:0] PAT_E = 64'hDEAD_BEEF_0BAD_F00D;

    initial begin
        rst = 1'b0;
        s_start = 1'b0; s_pdata = '0;
        d_start = 1'b0; d_pdata = '0;

        // Reset held for three edges
        repeat (3) step();
        chk("rst_clrn",  d_clrn, 0);
        chk("rst_pen",   d_pen,  1);
        chk("rst_busy",  d_busy, 0);
        chk("rst_sclk",  d_clk,  0);
        chk("rst_done",  d_done, 0);
        chk("rst_sout",  d_sout, 0);
        chk("rst_s_clrn", s_clrn, 0);
        rst = 1'b1;
        step();
        chk("rel_clrn",   d_clrn, 1);
        chk("rel_s_clrn", s_clrn, 1);
        chk("rel_busy",   d_busy, 0);

        // Small instance: 8'hA5, DIV=1
        s_pdata = 8'hA5;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        chk("s_first_busy", s_busy, 1);
        chk("s_first_pen",  s_pen,  0);
        chk("s_first_sout", s_sout, 1);
        chk("s_first_sclk", s_clk,  0);
        n = 1; done_at = 0; srises = 0; sbits = '0; sprev = s_clk;
        s_busy_at_done = 1'b1; s_pen_at_done = 1'b0;
        for (int i = 0; i < 40 && done_at == 0; i++) begin
            if (s_done) begin
                done_at = n;
                s_busy_at_done = s_busy;
                s_pen_at_done = s_pen;
            end
            if (s_clk && !sprev) begin
                srises++;
                sbits = {sbits[6:0], s_sout};
            end
            sprev = s_clk;
            step();
            n++;
        end
        chk("s_done_cycle", done_at, 18);
        chk("s_rises",      srises,  8);
        chk("s_bits",       sbits,   8'hA5);
        chk("s_done_busy",  s_busy_at_done, 0);
        chk("s_done_pen",   s_pen_at_done,  1);

        // Default instance: single bits at both ends
        clear_mon();
        d_pdata = 64'h8000_0000_0000_0001;
        d_start = 1'b1;
        step();
        t0 = cyc;
        d_start = 1'b0;
        for (int i = 0; i < 400 && done_cyc.size() < 1; i++) step();
        repeat (5) step();
        chk("t3_done_count", done_cyc.size(), 1);
        chk("t3_latency",    done_cyc[0] - t0, 259);
        chk("t3_bits",       fr_bits[0], 64'h8000_0000_0000_0001);
        chk("t3_rises",      fr_rises[0], 64);
        chk("t3_pen_low",    lo_runs[0], 258);
        chk("t3_idle_busy",  d_busy, 0);

        // Start held high: back-to-back frames, pdata changes mid-frame
        clear_mon();
        d_pdata = PAT_A;
        d_start = 1'b1;
        step();
        repeat (100) step();
        d_pdata = PAT_B;
        for (int i = 0; i < 400 && done_cyc.size() < 1; i++) step();
        repeat (100) step();
        d_pdata = PAT_C;
        for (int i = 0; i < 400 && done_cyc.size() < 2; i++) step();
        d_start = 1'b0;
        for (int i = 0; i < 400 && done_cyc.size() < 3; i++) step();
        repeat (300) step();
        chk("t4_done_count", done_cyc.size(), 3);
        chk("t4_frame0",     fr_bits[0], PAT_A);
        chk("t4_frame1",     fr_bits[1], PAT_B);
        chk("t4_frame2",     fr_bits[2], PAT_C);
        chk("t4_gap_count",  hi_runs.size(), 2);
        chk("t4_gap0",       hi_runs[0], 1);
        chk("t4_gap1",       hi_runs[1], 1);
        chk("t4_pen_low1",   lo_runs[1], 258);
        chk("t4_busy_pen",   busy_pen_err, 0);

        // Two start pulses inside one frame queue exactly one extra frame
        clear_mon();
        d_pdata = PAT_D;
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        repeat (8) step();
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        d_pdata = PAT_E;
        repeat (39) step();
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        repeat (800) step();
        chk("t5_done_count", done_cyc.size(), 2);
        chk("t5_frame0",     fr_bits[0], PAT_D);
        chk("t5_frame1",     fr_bits[1], PAT_E);
        chk("t5_gap",        hi_runs[0], 1);

        // Reset during bit 20 with a request pending
        clear_mon();
        d_pdata = PAT_B;
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        repeat (8) step();
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        repeat (72) step();
        chk("t6_busy_pre", d_busy, 1);
        rst = 1'b0;
        step();
        chk("t6_busy", d_busy, 0);
        chk("t6_pen",  d_pen,  1);
        chk("t6_sclk", d_clk,  0);
        chk("t6_sout", d_sout, 0);
        chk("t6_clrn", d_clrn, 0);
        chk("t6_done", d_done, 0);
        rst = 1'b1;
        step();
        chk("t6_clrn_rel", d_clrn, 1);
        repeat (600) step();
        chk("t6_no_done", done_cyc.size(), 0);
        chk("t6_idle",    d_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
